// File: rtl/iterative_divider_pkg.sv
// rtl/iterative_divider_pkg.sv - shared states and constants for the iterative divider
package iterative_divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

    // One quotient bit is produced per RUN cycle
    localparam int DIV_ITERATIONS = 32;

    // Start cycle to done pulse: 1 latch + 32 RUN + 1 FIX edges
    localparam int DIV_LATENCY = 34;

endpackage

// File: rtl/iterative_divider_div_step.sv
// rtl/iterative_divider_div_step.sv - one combinational restoring divide iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // Partial remainder keeps the shifted-out MSB so the compare cannot overflow
    logic [WIDTH:0] partial;
    logic           ge;

    assign partial = {rem_in, dvd_bit};
    assign ge      = (partial >= {1'b0, divisor});

    // When the subtraction is taken the result is below the divisor, so WIDTH bits suffice
    always_comb begin
        q_bit   = ge;
        rem_out = partial[WIDTH-1:0];
        if (ge) begin
            rem_out = partial[WIDTH-1:0] - divisor;
        end
    end

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle DIV/DIVU engine with stall request
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_is_unsigned,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient as it shifts
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] dsr_q, dsr_d;     // divisor magnitude
    logic [WIDTH-1:0] raw_q, raw_d;     // dividend as presented, for the divide-by-zero result
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dvz_q, dvz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;

    logic             accept;
    logic             dvd_sign, dsr_sign;
    logic [WIDTH-1:0] dvd_mag, dsr_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             last_iter;

    assign accept    = (state_q == DIV_IDLE) && i_start && !i_cancel;
    assign dvd_sign  = !i_is_unsigned && i_dividend[WIDTH-1];
    assign dsr_sign  = !i_is_unsigned && i_divisor[WIDTH-1];
    assign dvd_mag   = dvd_sign ? -i_dividend : i_dividend;
    assign dsr_mag   = dsr_sign ? -i_divisor  : i_divisor;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Next-state, datapath updates and cancel override
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        raw_d   = raw_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dvz_d   = dvz_q;
        quot_d  = quot_q;
        remd_d  = remd_q;

        case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    dvd_d   = dvd_mag;
                    dsr_d   = dsr_mag;
                    rem_d   = '0;
                    raw_d   = i_dividend;
                    cnt_d   = '0;
                    q_neg_d = dvd_sign ^ dsr_sign;
                    r_neg_d = dvd_sign;
                    dvz_d   = (i_divisor == '0);
                    state_d = DIV_RUN;
                end
            end
            DIV_RUN: begin
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    cnt_d   = '0;
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                if (dvz_q) begin
                    quot_d = '1;
                    remd_d = raw_q;
                end else begin
                    quot_d = q_neg_q ? -dvd_q : dvd_q;
                    remd_d = r_neg_q ? -rem_q : rem_q;
                end
                state_d = DIV_DONE;
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        // A flush abandons the operation and leaves the published results alone
        if (i_cancel) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
            quot_d  = quot_q;
            remd_d  = remd_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            raw_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dvz_q   <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            raw_q   <= raw_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dvz_q   <= dvz_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
        end
    end

    // Busy drops in DONE so the pipeline advances in the cycle HI/LO are written
    assign o_busy      = accept || (state_q == DIV_RUN) || (state_q == DIV_FIX);
    assign o_done      = (state_q == DIV_DONE) && !i_cancel;
    assign o_quotient  = quot_q;
    assign o_remainder = remd_q;

endmodule
